// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared FSM state type and FIFO level-width helper
// for the SPI transaction sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    CAPTURE   = 3'd4
  } seq_state_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo: synchronous first-word-fall-through FIFO.
// Pointers carry one extra wrap bit to tell full from empty.
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
              && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next storage and pointer values for push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Storage and pointer registers; reset flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: TX/RX FIFOs plus launch FSM driving an SPI master.
// Optional watchdog abort enabled by macro SPI_SEQ_WDOG_EN.
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [lvl_w(FIFO_DEPTH)-1:0] tx_level,
  output logic [lvl_w(FIFO_DEPTH)-1:0] rx_level,
  output logic                         m_start_tx,
  output logic [DATA_WIDTH-1:0]        m_tx_data,
  input  logic                         m_busy,
  input  logic                         m_irq,
  input  logic [DATA_WIDTH-1:0]        m_rx_data,
  output logic                         timeout
);

  seq_state_t          state_q, state_d;
  logic                start_q, start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic                tx_pop, rx_push;
  logic                tx_full, tx_empty;
  logic                rx_full, rx_empty;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                wdog_hit;

  assign wr_ready   = !tx_full;
  assign rd_valid   = !rx_empty;
  assign m_start_tx = start_q;
  assign m_tx_data  = tx_data_q;
  assign timeout    = wdog_hit;

  spi_seq_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid),
    .pop   (tx_pop),
    .wdata (wr_data),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  spi_seq_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rd_ready),
    .wdata (cap_q),
    .rdata (rd_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

`ifdef SPI_SEQ_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        waiting;

  assign waiting  = (state_q == WAIT_BUSY)
                 || (state_q == WAIT_DONE);
  // A completion in the limit cycle wins over the abort.
  assign wdog_hit = ((state_q == WAIT_BUSY)
                 || (state_q == WAIT_DONE && !m_irq))
                 && (wdog_q == 16'(WDOG_CYCLES - 1));

  // Cycle count since launch while waiting on the master.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == LAUNCH) begin
      wdog_d = '0;
    end else if (waiting) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // Launch FSM: next state, FIFO strobes and master outputs.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    tx_data_d = tx_data_q;
    cap_d     = cap_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && !tx_empty && !rx_full && !m_busy) begin
          state_d   = LAUNCH;
          start_d   = 1'b1;
          tx_data_d = tx_head;
        end
      end
      LAUNCH: begin
        tx_pop  = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (m_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (m_irq) begin
          cap_d   = m_rx_data;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rx_push = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wdog_hit) state_d = IDLE;
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      tx_data_q <= '0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
      cap_q     <= cap_d;
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer: directed bench with a simple SPI master model.
// Master answers each word w with rx = w + 16'h9999.
module tb_spi_txn_sequencer;
  import spi_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic [4:0]  tx_level, rx_level;
  logic        m_start_tx;
  logic [15:0] m_tx_data;
  logic        m_busy;
  logic        m_irq;
  logic [15:0] m_rx_data;
  logic        timeout;

  int vec = 0;
  int errs = 0;
  int start_cycles = 0;
  int timeout_seen = 0;
  logic hang = 1'b0;
  logic [15:0] sent_q [$];

  spi_txn_sequencer #(
    .DATA_WIDTH  (16),
    .FIFO_DEPTH  (16),
    .WDOG_CYCLES (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .tx_level   (tx_level),
    .rx_level   (rx_level),
    .m_start_tx (m_start_tx),
    .m_tx_data  (m_tx_data),
    .m_busy     (m_busy),
    .m_irq      (m_irq),
    .m_rx_data  (m_rx_data),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_start_tx) start_cycles++;
    if (timeout) timeout_seen++;
  end

  initial begin
    logic [15:0] w;
    m_busy = 1'b0;
    m_irq = 1'b0;
    m_rx_data = '0;
    forever begin
      @(negedge clk);
      if (m_start_tx && !rst) begin
        w = m_tx_data;
        sent_q.push_back(w);
        m_busy = 1'b1;
        for (int i = 0; i < 4 && !rst; i++) @(negedge clk);
        if (hang) begin
          for (int i = 0; i < 200 && !timeout && !rst; i++)
            @(negedge clk);
        end else if (!rst) begin
          m_rx_data = w + 16'h9999;
          m_irq = 1'b1;
          @(negedge clk);
        end
        m_irq = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic pop_check(input logic [15:0] exp, input string nm);
    @(negedge clk);
    vec++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      errs++;
      $display("FAIL %s: rd_valid=%b rd_data=%h want 1/%h",
               nm, rd_valid, rd_data, exp);
    end
    rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
  endtask

  task automatic wait_rx(input int lvl, input int lim, input string nm);
    int n;
    for (n = 0; n < lim; n++) begin
      @(negedge clk);
      if (rx_level == 5'(lvl)) break;
    end
    vec++;
    if (rx_level !== 5'(lvl)) begin
      errs++;
      $display("FAIL %s: rx_level=%0d want %0d", nm, rx_level, lvl);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++;
    if (m_start_tx !== 1'b0 || m_tx_data !== 16'h0 ||
        timeout !== 1'b0 || wr_ready !== 1'b1 ||
        rd_valid !== 1'b0 || tx_level !== 5'd0 ||
        rx_level !== 5'd0) begin
      errs++;
      $display("FAIL reset: st=%b td=%h to=%b wr=%b rv=%b tl=%0d rl=%0d want 0/0/0/1/0/0/0",
               m_start_tx, m_tx_data, timeout, wr_ready,
               rd_valid, tx_level, rx_level);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int s;
    int n;
    s = start_cycles;
    sent_q.delete();
    enable = 1'b1;
    push(16'h1234);
    vec++;
    if (tx_level !== 5'd1 || m_start_tx !== 1'b0) begin
      errs++;
      $display("FAIL single_lvl: tx_level=%0d start=%b want 1/0",
               tx_level, m_start_tx);
    end
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rd_valid) break;
    end
    vec++;
    if (start_cycles - s !== 1 || sent_q.size() != 1) begin
      errs++;
      $display("FAIL single_start: pulses=%0d words=%0d want 1/1",
               start_cycles - s, sent_q.size());
    end else if (sent_q[0] !== 16'h1234) begin
      errs++;
      $display("FAIL single_txd: m_tx_data=%h want 1234", sent_q[0]);
    end
    pop_check(16'hABCD, "single_rx");
  endtask

  task automatic test_fill();
    int bad;
    enable = 1'b0;
    sent_q.delete();
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
    vec++;
    if (wr_ready !== 1'b0 || tx_level !== 5'd16) begin
      errs++;
      $display("FAIL fill_full: wr_ready=%b tx_level=%0d want 0/16",
               wr_ready, tx_level);
    end
    push(16'hDEAD);
    vec++;
    if (tx_level !== 5'd16) begin
      errs++;
      $display("FAIL fill_ovf: tx_level=%0d want 16", tx_level);
    end
    enable = 1'b1;
    wait_rx(16, 2000, "fill_rx");
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (i >= sent_q.size() || sent_q[i] !== 16'h0100 + 16'(i)) bad++;
    vec++;
    if (bad != 0 || sent_q.size() != 16 || tx_level !== 5'd0) begin
      errs++;
      $display("FAIL fill_order: bad=%0d words=%0d tx_level=%0d want 0/16/0",
               bad, sent_q.size(), tx_level);
    end
  endtask

  task automatic test_rx_full();
    int s;
    int n;
    s = start_cycles;
    push(16'h0001);
    repeat (20) @(negedge clk);
    vec++;
    if (start_cycles != s || tx_level !== 5'd1) begin
      errs++;
      $display("FAIL rxfull_block: pulses=%0d tx_level=%0d want 0/1",
               start_cycles - s, tx_level);
    end
    pop_check(16'h0100 + 16'h9999, "rxfull_head");
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_start_tx) break;
    end
    vec++;
    if (m_start_tx !== 1'b1 || m_tx_data !== 16'h0001) begin
      errs++;
      $display("FAIL rxfull_launch: start=%b m_tx_data=%h want 1/0001",
               m_start_tx, m_tx_data);
    end
    wait_rx(16, 50, "rxfull_refill");
    for (int i = 1; i < 16; i++)
      pop_check(16'h0100 + 16'(i) + 16'h9999, "rxfull_drain");
    pop_check(16'h0001 + 16'h9999, "rxfull_last");
  endtask

  task automatic test_reset_mid();
    int n;
    int s;
    enable = 1'b1;
    push(16'h5555);
    push(16'h6666);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_busy) break;
    end
    repeat (2) @(negedge clk);
    vec++;
    if (dut.state_q !== WAIT_DONE || tx_level !== 5'd1) begin
      errs++;
      $display("FAIL rstmid_pre: state=%0d tx_level=%0d want 3/1",
               dut.state_q, tx_level);
    end
    rst = 1'b1;
    #1;
    vec++;
    if (m_start_tx !== 1'b0 || m_tx_data !== 16'h0 ||
        tx_level !== 5'd0 || rx_level !== 5'd0 ||
        wr_ready !== 1'b1 || rd_valid !== 1'b0 ||
        dut.state_q !== IDLE) begin
      errs++;
      $display("FAIL rstmid: st=%b td=%h tl=%0d rl=%0d wr=%b rv=%b state=%0d want 0/0/0/0/1/0/0",
               m_start_tx, m_tx_data, tx_level, rx_level,
               wr_ready, rd_valid, dut.state_q);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    s = start_cycles;
    repeat (10) @(negedge clk);
    vec++;
    if (start_cycles != s || rx_level !== 5'd0) begin
      errs++;
      $display("FAIL rstmid_post: pulses=%0d rx_level=%0d want 0/0",
               start_cycles - s, rx_level);
    end
  endtask

  task automatic test_full_push_pop();
    int n;
    logic saw;
    saw = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 16; i++) push(16'h0200 + 16'(i));
    @(negedge clk);
    enable = 1'b1;
    wr_valid = 1'b1;
    wr_data = 16'h0300;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m_start_tx) begin
        saw = 1'b1;
        vec++;
        if (wr_ready !== 1'b0 || tx_level !== 5'd16) begin
          errs++;
          $display("FAIL fpp_launch: wr_ready=%b tx_level=%0d want 0/16",
                   wr_ready, tx_level);
        end
      end
      if (wr_ready) begin
        @(posedge clk);
        #1 wr_valid = 1'b0;
        break;
      end
    end
    wr_valid = 1'b0;
    vec++;
    if (!saw || tx_level !== 5'd16) begin
      errs++;
      $display("FAIL fpp_level: launch=%b tx_level=%0d want 1/16",
               saw, tx_level);
    end
    wait_rx(16, 3000, "fpp_rx");
    for (int i = 0; i < 16; i++)
      pop_check(16'h0200 + 16'(i) + 16'h9999, "fpp_order");
    wait_rx(1, 50, "fpp_tail_lvl");
    pop_check(16'h0300 + 16'h9999, "fpp_tail");
  endtask

`ifdef SPI_SEQ_WDOG_EN
  task automatic test_timeout();
    int n;
    int m;
    hang = 1'b1;
    enable = 1'b0;
    push(16'h7777);
    push(16'h8888);
    enable = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_start_tx) break;
    end
    for (m = 0; m < 200; m++) begin
      @(negedge clk);
      if (timeout) break;
    end
    hang = 1'b0;
    vec++;
    if (m + 1 != 64 || rx_level !== 5'd0) begin
      errs++;
      $display("FAIL wdog: cycles=%0d rx_level=%0d want 64/0",
               m + 1, rx_level);
    end
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (m_start_tx) break;
    end
    vec++;
    if (m_start_tx !== 1'b1 || m_tx_data !== 16'h8888) begin
      errs++;
      $display("FAIL wdog_next: start=%b m_tx_data=%h want 1/8888",
               m_start_tx, m_tx_data);
    end
    wait_rx(1, 50, "wdog_rx");
    pop_check(16'h8888 + 16'h9999, "wdog_data");
  endtask
`else
  task automatic test_timeout();
    vec++;
    if (timeout_seen != 0) begin
      errs++;
      $display("FAIL no_wdog: timeout pulses=%0d want 0", timeout_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_rx_full();
    test_reset_mid();
    test_full_push_pop();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
